// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Configuration macro: MEM_ARB_DPRIO_EN (see mem_arb_pick).
package mem_arb_pkg;

  localparam int ARB_N = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Memory write-type encoding, shared by d_we and m_memwrite.
  localparam logic [1:0] MW_NONE  = 2'd0;
  localparam logic [1:0] MW_WORD  = 2'd1;
  localparam logic [1:0] MW_BYTE  = 2'd2;
  localparam logic [1:0] MW_DWORD = 2'd3;

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
//
// Handshake: a requester raises *_req with its fields stable and keeps them
// until the one-cycle *_gnt pulse; it must drop or change *_req during that
// gnt cycle. The matching *_rvalid pulses exactly one cycle after *_gnt and
// carries the read data (for data writes it only marks completion). There is
// no back-pressure on the response side.
interface mem_arb_if #(parameter int N = 64);

  // Instruction-fetch port
  logic          i_req;
  logic [N-1:0]  i_adr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;

  // Data port
  logic          d_req;
  logic [1:0]    d_we;
  logic          d_readtype;
  logic [N-1:0]  d_adr;
  logic [N-1:0]  d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [N-1:0]  d_rdata;

  // Shared memory port
  logic [1:0]    m_memwrite;
  logic          m_readtype;
  logic [N-1:0]  m_adr;
  logic [N-1:0]  m_wdata;
  logic [N-1:0]  m_rdata;

  // Arbiter side
  modport slave (
    input  i_req, i_adr, d_req, d_we, d_readtype, d_adr, d_wdata, m_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output m_memwrite, m_readtype, m_adr, m_wdata
  );

  // Requesters plus memory side
  modport master (
    output i_req, i_adr, d_req, d_we, d_readtype, d_adr, d_wdata, m_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  m_memwrite, m_readtype, m_adr, m_wdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way combinational picker between the fetch and data requesters.
// Default: round-robin on ties (the port not served last wins).
// With MEM_ARB_DPRIO_EN defined: the data port always wins ties and
// last_served_i is ignored.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  owner_t last_served_i,
  output owner_t winner_o,
  output logic   valid_o
);

`ifdef MEM_ARB_DPRIO_EN
  logic unused_last;
  assign unused_last = last_served_i;
`endif

  // Select the winner from the current requests.
  always_comb begin
    valid_o  = i_req_i | d_req_i;
    winner_o = OWN_D;
    if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_DPRIO_EN
      winner_o = OWN_D;
`else
      winner_o = (last_served_i == OWN_I) ? OWN_D : OWN_I;
`endif
    end else if (i_req_i) begin
      winner_o = OWN_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer sharing one memory address/write path between the
// instruction-fetch port and the data port of the multicycle MIPS64 core.
// One access in flight: IDLE/RESP arbitrate -> ACCESS drives memory -> RESP
// returns the response. Configuration macro: MEM_ARB_DPRIO_EN (fixed data
// priority instead of round-robin, selected inside mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic     clk,
  input  logic     reset,
  mem_arb_if.slave bus,
  output logic     busy,
  output state_t   dbg_state_o
);

  state_t         state_q;
  owner_t         owner_q;
  owner_t         last_q;
  logic [N-1:0]   adr_q;
  logic [1:0]     we_q;
  logic           rt_q;
  logic [N-1:0]   wdata_q;
  logic           i_gnt_q;
  logic           d_gnt_q;
  logic           i_rvalid_q;
  logic           d_rvalid_q;
  logic [31:0]    i_rdata_q;
  logic [N-1:0]   d_rdata_q;

  owner_t         pick_winner;
  logic           pick_valid;

  mem_arb_pick u_pick (
    .i_req_i       (bus.i_req),
    .d_req_i       (bus.d_req),
    .last_served_i (last_q),
    .winner_o      (pick_winner),
    .valid_o       (pick_valid)
  );

  // Control FSM with registered command, grant and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_I;
      last_q     <= OWN_I;
      adr_q      <= '0;
      we_q       <= MW_NONE;
      rt_q       <= 1'b0;
      wdata_q    <= '0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      unique case (state_q)
        IDLE, RESP: begin
          if (pick_valid) begin
            state_q <= ACCESS;
            owner_q <= pick_winner;
            last_q  <= pick_winner;
            if (pick_winner == OWN_D) begin
              adr_q   <= bus.d_adr;
              we_q    <= bus.d_we;
              rt_q    <= bus.d_readtype;
              wdata_q <= bus.d_wdata;
              d_gnt_q <= 1'b1;
            end else begin
              // Fetches are always plain word reads.
              adr_q   <= bus.i_adr;
              we_q    <= MW_NONE;
              rt_q    <= 1'b0;
              wdata_q <= '0;
              i_gnt_q <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          if (owner_q == OWN_D) begin
            d_rdata_q  <= bus.m_rdata;
            d_rvalid_q <= 1'b1;
          end else begin
            // Memory returns the selected word in the low half.
            i_rdata_q  <= bus.m_rdata[31:0];
            i_rvalid_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Writes are only presented during ACCESS and never while reset is high.
  assign bus.m_memwrite = (state_q == ACCESS && !reset) ? we_q : MW_NONE;
  assign bus.m_readtype = rt_q;
  assign bus.m_adr      = adr_q;
  assign bus.m_wdata    = wdata_q;

  assign bus.i_gnt      = i_gnt_q;
  assign bus.d_gnt      = d_gnt_q;
  assign bus.i_rvalid   = i_rvalid_q;
  assign bus.d_rvalid   = d_rvalid_q;
  assign bus.i_rdata    = i_rdata_q;
  assign bus.d_rdata    = d_rdata_q;

  assign busy           = (state_q != IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions scored against a transaction-level memory/arbitration model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic   clk;
  logic   reset;
  logic   busy;
  state_t dbg_state;

  mem_arb_if #(.N(64)) bus ();

  mem_arbiter #(.N(64)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- memory helpers (big-endian MIPS64) ----------------
  function automatic logic [31:0] word_sel(input logic [63:0] dw, input logic [63:0] adr);
    return adr[2] ? dw[31:0] : dw[63:32];
  endfunction

  function automatic logic [63:0] apply_write(input logic [63:0] old, input logic [1:0] we,
                                              input logic [63:0] adr, input logic [63:0] wd);
    logic [63:0] r;
    int sh;
    r  = old;
    sh = 7 - int'(adr[2:0]);
    case (we)
      2'd1: if (adr[2]) r[31:0] = wd[31:0]; else r[63:32] = wd[31:0];
      2'd2: r[sh*8 +: 8] = wd[7:0];
      2'd3: r = wd;
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- memory stand-in ----------------
  logic [63:0] mem [16];
  logic        mem_clr;
  logic [63:0] rd_dw;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 16; k++) mem[k] <= '0;
    end else if (bus.m_memwrite != 2'd0) begin
      mem[bus.m_adr[6:3]] <= apply_write(mem[bus.m_adr[6:3]], bus.m_memwrite, bus.m_adr, bus.m_wdata);
    end
  end

  always_comb begin
    rd_dw       = mem[bus.m_adr[6:3]];
    bus.m_rdata = bus.m_readtype ? rd_dw : {32'h0, word_sel(rd_dw, bus.m_adr)};
  end

  // ---------------- reference model state ----------------
  logic [63:0] ref_mem [16];
  bit          m_last;   // 0 = fetch served last, 1 = data served last

  function automatic bit tie_winner(input bit last);
`ifdef MEM_ARB_DPRIO_EN
    return 1'b1 | last;
`else
    return ~last;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_adr = '0;
    bus.d_req = 1'b0; bus.d_we = 2'd0; bus.d_readtype = 1'b0;
    bus.d_adr = '0; bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    m_last = 1'b0;
  endtask

  // Issue up to one fetch and one data request together and score grants
  // and responses against the model.
  task automatic run_txn(input bit do_i, input logic [63:0] ia, input bit do_d,
                         input logic [1:0] we, input bit rt,
                         input logic [63:0] da, input logic [63:0] wd);
    bit ip, dp, rdue, rown, rchk, ew, aw;
    logic [63:0] rexp;
    int cyc, idx;
    ip = do_i; dp = do_d; rdue = 0; rown = 0; rchk = 0; rexp = '0; cyc = 0;
    bus.i_req = do_i; bus.i_adr = ia;
    bus.d_req = do_d; bus.d_we = we; bus.d_readtype = rt; bus.d_adr = da; bus.d_wdata = wd;
    while ((ip || dp || rdue) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      total++;
      if (rdue) begin
        if (rown) begin
          if (bus.d_rvalid !== 1'b1 || bus.i_rvalid !== 1'b0 || (rchk && bus.d_rdata !== rexp)) begin
            bad++;
            $display("FAIL d_resp: i/d_rvalid=%b/%b d_rdata=%h, required 0/1 d_rdata=%h (chk=%0d)",
                     bus.i_rvalid, bus.d_rvalid, bus.d_rdata, rexp, rchk);
          end
        end else begin
          if (bus.i_rvalid !== 1'b1 || bus.d_rvalid !== 1'b0 || bus.i_rdata !== rexp[31:0]) begin
            bad++;
            $display("FAIL i_resp: i/d_rvalid=%b/%b i_rdata=%h, required 1/0 i_rdata=%h",
                     bus.i_rvalid, bus.d_rvalid, bus.i_rdata, rexp[31:0]);
          end
        end
        rdue = 0;
      end else if (bus.i_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL stray_rvalid: i/d_rvalid=%b/%b, required 0/0", bus.i_rvalid, bus.d_rvalid);
      end
      if (bus.i_gnt === 1'b1 || bus.d_gnt === 1'b1) begin
        ew = (ip && dp) ? tie_winner(m_last) : dp;
        aw = bus.d_gnt;
        total++;
        if ((bus.i_gnt & bus.d_gnt) !== 1'b0 || !(ip || dp) || aw !== ew) begin
          bad++;
          $display("FAIL grant: i/d_gnt=%b/%b, required winner=%s (pending i=%0d d=%0d)",
                   bus.i_gnt, bus.d_gnt, ew ? "D" : "I", ip, dp);
        end
        m_last = ew;
        rdue   = 1;
        rown   = ew;
        if (ew) begin
          dp = 0; bus.d_req = 1'b0;
          idx = int'(da[6:3]);
          if (we == 2'd0) begin
            rchk = 1;
            rexp = rt ? ref_mem[idx] : {32'h0, word_sel(ref_mem[idx], da)};
          end else begin
            rchk = 0;
            ref_mem[idx] = apply_write(ref_mem[idx], we, da, wd);
          end
        end else begin
          ip = 0; bus.i_req = 1'b0;
          rchk = 1;
          rexp = {32'h0, word_sel(ref_mem[int'(ia[6:3])], ia)};
        end
      end
    end
    if (ip || dp || rdue) begin
      total++; bad++;
      $display("FAIL txn_timeout: pending i=%0d d=%0d resp=%0d after %0d cycles, required done", ip, dp, rdue, cyc);
      idle_inputs();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_pulses: gnt/rvalid/busy=%b, required 00000",
               {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, busy});
    end
    total++;
    if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 64'h0) begin
      bad++;
      $display("FAIL reset_rdata: i_rdata=%h d_rdata=%h, required 0/0", bus.i_rdata, bus.d_rdata);
    end
    total++;
    if (bus.m_memwrite !== 2'd0 || bus.m_readtype !== 1'b0 || bus.m_adr !== 64'h0 || bus.m_wdata !== 64'h0) begin
      bad++;
      $display("FAIL reset_cmd: memwrite=%0d readtype=%0d adr=%h wdata=%h, required all 0",
               bus.m_memwrite, bus.m_readtype, bus.m_adr, bus.m_wdata);
    end
    total++;
    if (dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state: state=%0d, required %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if ({busy, bus.m_memwrite, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid} !== 7'b0) begin
        bad++;
        $display("FAIL idle_quiet: busy/memwrite/gnt/rvalid=%b at idle cycle %0d, required 0",
                 {busy, bus.m_memwrite, bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid}, k);
      end
    end
  endtask

  task automatic test_fetch();
    run_txn(0, 64'h0, 1, 2'd3, 0, 64'h0, 64'h0123456789ABCDEF);
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_adr = 64'h4;
    @(negedge clk);
    total++;
    if (bus.i_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
      bad++;
      $display("FAIL fetch_gnt: i/d_gnt=%b/%b one cycle after req, required 1/0", bus.i_gnt, bus.d_gnt);
    end
    bus.i_req = 1'b0;
    m_last = 1'b0;
    @(negedge clk);
    total++;
    if (bus.i_rvalid !== 1'b1 || bus.i_rdata !== 32'h89ABCDEF) begin
      bad++;
      $display("FAIL fetch_data: i_rvalid=%b i_rdata=%h, required 1 89abcdef", bus.i_rvalid, bus.i_rdata);
    end
    @(negedge clk);
    total++;
    if (bus.i_rvalid !== 1'b0) begin
      bad++;
      $display("FAIL fetch_pulse: i_rvalid=%b in second cycle, required 0", bus.i_rvalid);
    end
  endtask

  task automatic test_dword();
    int cnt;
    bit seen3;
    cnt = 0; seen3 = 0;
    bus.d_req = 1'b1; bus.d_we = 2'd3; bus.d_readtype = 1'b0;
    bus.d_adr = 64'h10; bus.d_wdata = 64'hDEADBEEFCAFEF00D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.m_memwrite !== 2'd0) begin
        cnt++;
        if (bus.m_memwrite === 2'd3 && bus.d_gnt === 1'b1 && bus.m_adr === 64'h10) seen3 = 1;
      end
      if (bus.d_gnt === 1'b1) bus.d_req = 1'b0;
    end
    bus.d_req = 1'b0;
    ref_mem[2] = 64'hDEADBEEFCAFEF00D;
    m_last = 1'b1;
    total++;
    if (cnt != 1 || !seen3) begin
      bad++;
      $display("FAIL dword_memwrite: write cycles=%0d seen_type3=%0d, required 1/1", cnt, seen3);
    end
    run_txn(0, 64'h0, 1, 2'd0, 1, 64'h10, 64'h0);
    total++;
    if (bus.d_rdata !== 64'hDEADBEEFCAFEF00D) begin
      bad++;
      $display("FAIL dword_read: d_rdata=%h, required deadbeefcafef00d", bus.d_rdata);
    end
  endtask

  task automatic test_byte();
    run_txn(0, 64'h0, 1, 2'd3, 0, 64'h10, 64'h0);
    run_txn(0, 64'h0, 1, 2'd2, 0, 64'h17, 64'h55555555555555AA);
    run_txn(0, 64'h0, 1, 2'd0, 1, 64'h10, 64'h0);
    total++;
    if (bus.d_rdata !== 64'h00000000000000AA) begin
      bad++;
      $display("FAIL byte_write: word2=%h, required 00000000000000aa", bus.d_rdata);
    end
  endtask

  task automatic test_back_to_back();
    bit own [4];
    logic [3:0] expv, actv;
    do_reset();
`ifdef MEM_ARB_DPRIO_EN
    own = '{1'b1, 1'b1, 1'b1, 1'b1};
`else
    own = '{1'b1, 1'b0, 1'b1, 1'b0};
`endif
    bus.i_req = 1'b1; bus.i_adr = 64'h8;
    bus.d_req = 1'b1; bus.d_we = 2'd0; bus.d_readtype = 1'b1; bus.d_adr = 64'h18;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k % 2 == 0) expv = own[k/2] ? 4'b0100 : 4'b1000;
      else            expv = own[k/2] ? 4'b0001 : 4'b0010;
      actv = {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid};
      total++;
      if (actv !== expv) begin
        bad++;
        $display("FAIL back_to_back: cycle %0d i_gnt/d_gnt/i_rv/d_rv=%b, required %b", k, actv, expv);
      end
    end
    idle_inputs();
    do_reset();
  endtask

  task automatic test_reset_mid();
    bit got;
    got = 0;
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 2'd3; bus.d_readtype = 1'b0;
    bus.d_adr = 64'h20; bus.d_wdata = 64'hFFFFFFFFFFFFFFFF;
    for (int k = 0; k < 5 && !got; k++) begin
      @(negedge clk);
      if (bus.d_gnt === 1'b1) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL rstmid_gnt: no d_gnt within 5 cycles, required grant");
    end
    reset = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, busy, bus.m_memwrite, bus.m_readtype} !== 8'b0 ||
        bus.m_adr !== 64'h0 || bus.m_wdata !== 64'h0 || bus.i_rdata !== 32'h0 || bus.d_rdata !== 64'h0) begin
      bad++;
      $display("FAIL rstmid_outputs: ctl=%b adr=%h wdata=%h rdata=%h/%h, required all 0",
               {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, busy, bus.m_memwrite, bus.m_readtype},
               bus.m_adr, bus.m_wdata, bus.i_rdata, bus.d_rdata);
    end
    total++;
    if (mem[4] !== ref_mem[4]) begin
      bad++;
      $display("FAIL rstmid_nowrite: mem[0x20]=%h, required %h", mem[4], ref_mem[4]);
    end
    reset  = 1'b0;
    m_last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.d_rvalid !== 1'b0 || bus.i_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_rvalid: i/d_rvalid=%b/%b after reset, required 0/0", bus.i_rvalid, bus.d_rvalid);
      end
    end
  endtask

  task automatic test_random();
    int sel;
    logic [1:0] we;
    bit rt;
    logic [63:0] ia, da, wd;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(1, 3);
      ia  = 64'($urandom_range(0, 31)) << 2;
      we  = 2'($urandom_range(0, 3));
      rt  = 1'($urandom_range(0, 1));
      case (we)
        2'd1: da = 64'($urandom_range(0, 31)) << 2;
        2'd2: da = 64'($urandom_range(0, 127));
        2'd3: da = 64'($urandom_range(0, 15)) << 3;
        default: da = rt ? (64'($urandom_range(0, 15)) << 3) : (64'($urandom_range(0, 31)) << 2);
      endcase
      wd = {$urandom, $urandom};
      run_txn(sel[0], ia, sel[1], we, rt, da, wd);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  task automatic test_final_mem();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (mem[k] !== ref_mem[k]) begin
        bad++;
        $display("FAIL final_mem: dword %0d=%h, required %h", k, mem[k], ref_mem[k]);
      end
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    mem_clr = 1'b1;
    reset   = 1'b1;
    m_last  = 1'b0;
    for (int k = 0; k < 16; k++) ref_mem[k] = '0;
    idle_inputs();
    @(negedge clk);
    mem_clr = 1'b0;
    test_reset();
    test_idle();
    test_fetch();
    test_dword();
    test_byte();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_final_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the shared 64-bit data/instruction memory of the multicycle MIPS64 core.
- Serves an instruction-fetch port (32-bit word reads) and a data port (byte/word/doubleword writes, word/doubleword reads).
- Shares the memory's single address/write path between the two ports: one access in flight, registered command, registered response.

Parameters:
N, 64, address/data width; matches memory word width.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
i_req  in  1  fetch request; i_adr held stable until i_gnt
i_adr  in  N  fetch byte address (bit 2 selects word)
i_gnt  out  1  one-cycle pulse: fetch request accepted
i_rvalid  out  1  one-cycle pulse: i_rdata valid
i_rdata  out  32  fetched instruction word
d_req  in  1  data request; d_* held stable until d_gnt
d_we  in  2  0 read, 1 word write, 2 byte write, 3 doubleword write
d_readtype  in  1  1 doubleword read, 0 word read
d_adr  in  N  data byte address
d_wdata  in  N  write data (low bits used for byte/word)
d_gnt  out  1  one-cycle pulse: data request accepted
d_rvalid  out  1  one-cycle pulse: read data valid / write done
d_rdata  out  N  read data
m_memwrite  out  2  to memory write-type (same encoding as d_we)
m_readtype  out  1  to memory
m_adr  out  N  to memory address
m_wdata  out  N  to memory write data
m_rdata  in  N  memory combinational read data
busy  out  1  state != IDLE

Behaviour:
- States IDLE, ACCESS, RESP. Reset (synchronous): state=IDLE, i_gnt=d_gnt=i_rvalid=d_rvalid=0, i_rdata=0, d_rdata=0, command regs=0, last_served=I.
- IDLE/RESP, edge with any req: pick winner, latch its fields into command regs (owner, adr, we, readtype, wdata), go ACCESS; winner's gnt=1 during ACCESS cycle only. No req: IDLE->IDLE, RESP->IDLE.
- Fetch command: we forced 0, readtype forced 0.
- ACCESS: m_* driven from command regs; m_memwrite nonzero for exactly this cycle, write commits at ACCESS-ending edge. At that edge capture m_rdata: fetch -> i_rdata = m_rdata[31:0] (memory places selected word in low half); data -> d_rdata = m_rdata. Go RESP.
- RESP: owner's rvalid=1 for one cycle (writes included; d_rdata then = pre-write readback, don't-care).
- Outside ACCESS: m_memwrite=0, other m_* hold command regs.
- Latency: req sampled at edge E0 -> gnt in cycle E0..E1 -> rvalid in cycle E1..E2. Sustained: one access per 2 cycles (RESP re-arbitrates).
- Requester must drop or change req during its gnt cycle; reqs ignored in ACCESS.
- Arbitration: both req -> grant port not in last_served; last_served updated on each grant. Single req -> granted.
- m_memwrite gated by !reset: no write commits in any reset cycle, even mid-ACCESS; reset mid-operation discards in-flight command, no rvalid issued.
- i_gnt/d_gnt and i_rvalid/d_rvalid never both high.

Optional Feature:
MEM_ARB_DPRIO_EN: defined -> fixed priority, data port always wins ties (fetch starvation permitted; last_served unused). Undefined -> round-robin as above.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, ACCESS, RESP), owner enum (OWN_I, OWN_D), memwrite constants MW_NONE=0, MW_WORD=1, MW_BYTE=2, MW_DWORD=3.
- One sub-module natural: mem_arb_pick (combinational two-way round-robin/priority picker; inputs i_req, d_req, last_served; outputs winner, valid).

Test Plan:
- Fetch only: i_req, i_adr=0x4, memory word0=0x0123456789ABCDEF -> i_gnt next cycle, i_rvalid one cycle later, i_rdata=0x89ABCDEF.
- Data doubleword write then read: d_we=3, adr=0x10, wdata=0xDEADBEEFCAFEF00D; then d_we=0, readtype=1 -> m_memwrite=3 exactly one cycle; d_rdata=0xDEADBEEFCAFEF00D.
- Byte write: d_we=2, adr=0x17, wdata=0xAA onto 0 -> readback of word 2 = 0x00000000000000AA.
- Both held continuously -> grants D,I,D,I (first D), one rvalid every 2 cycles; with MEM_ARB_DPRIO_EN all grants D.
- Reset asserted during ACCESS of d_we=3 -> target doubleword unchanged, no d_rvalid, all outputs 0 after edge, busy=0.
- Idle: no req for 10 cycles -> busy=0, m_memwrite=0, no gnt/rvalid pulses.
